// File: rtl/snake_sprite_renderer.sv
// -----------------------------------------------------------------------------
// snake_sprite_renderer
//
// Two-stage pixel pipeline that looks up a 16x16 sprite in an external
// combinational ROM and hands an opaque/colour result to the compositor.
//
//   Stage 1: sprite-local (u,v) from pixel minus origin, box test, rotation
//            into ROM row/col, registered ROM address.
//   Stage 2: registered colour from the ROM, colour-key transparency and
//            blink gating.
//
// Ports
//   i_clk, i_rst_n       pixel clock, asynchronous active-low reset
//   i_valid              pixel coordinate valid (display enable)
//   i_px, i_py           current pixel coordinate
//   i_org_x, i_org_y     sprite top-left corner
//   i_dir                0 native, 1 rot90cw, 2 rot180, 3 rot270cw
//   i_frame_start        one-cycle pulse at the start of each frame
//   i_blink_en           1 = sprite blinks, 0 = always visible
//   o_rom_addr           {row,col} address to the sprite ROM
//   i_rom_data           RGB returned by the ROM for o_rom_addr
//   o_valid, o_hit, o_rgb  pipelined pixel valid, opaque flag, colour
//
// Handshake: no flow control. One pixel is accepted every clock; o_valid
// mirrors i_valid two clocks later and the consumer must always take it.
// -----------------------------------------------------------------------------
module snake_sprite_renderer #(
  parameter int          XW           = 10,
  parameter logic [23:0] KEY_RGB      = 24'h181b1d,
  parameter int          BLINK_FRAMES = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [XW-1:0] i_px,
  input  logic [XW-1:0] i_py,
  input  logic [XW-1:0] i_org_x,
  input  logic [XW-1:0] i_org_y,
  input  logic [1:0]    i_dir,
  input  logic          i_frame_start,
  input  logic          i_blink_en,
  output logic [7:0]    o_rom_addr,
  input  logic [23:0]   i_rom_data,
  output logic          o_valid,
  output logic          o_hit,
  output logic [23:0]   o_rgb
);

  typedef enum logic {
    ST_VIS = 1'b0,
    ST_HID = 1'b1
  } blink_state_e;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Stage 1: address generation
  // ---------------------------------------------------------------------------
  logic [XW:0] du;
  logic [XW:0] dv;
  logic [3:0]  u;
  logic [3:0]  v;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        inbox;

  logic [7:0]  rom_addr_d, rom_addr_q;
  logic        s1_valid_d, s1_valid_q;
  logic        s1_in_d,    s1_in_q;

  always_comb begin
    // One extra bit so a pixel left of / above the origin wraps to a large
    // value and fails the box test instead of aliasing into the sprite.
    du = {1'b0, i_px} - {1'b0, i_org_x};
    dv = {1'b0, i_py} - {1'b0, i_org_y};
    u  = du[3:0];
    v  = dv[3:0];

    inbox = i_valid && (du[XW:4] == '0) && (dv[XW:4] == '0);

    row = v;
    col = u;
    case (i_dir)
      2'd0: begin row = v;          col = u;          end
      2'd1: begin row = 4'd15 - u;  col = v;          end
      2'd2: begin row = 4'd15 - v;  col = 4'd15 - u;  end
      2'd3: begin row = u;          col = 4'd15 - v;  end
      default: begin row = v;       col = u;          end
    endcase

    rom_addr_d = inbox ? {row, col} : 8'd0;
    s1_valid_d = i_valid;
    s1_in_d    = inbox;
  end

  // ---------------------------------------------------------------------------
  // Blink FSM: counts frame pulses, toggles visibility every BLINK_FRAMES
  // ---------------------------------------------------------------------------
  blink_state_e blink_state_d, blink_state_q;
  logic [7:0]   blink_cnt_d,   blink_cnt_q;

  always_comb begin
    blink_state_d = blink_state_q;
    blink_cnt_d   = blink_cnt_q;
    if (!i_blink_en) begin
      blink_state_d = ST_VIS;
      blink_cnt_d   = 8'd0;
    end else if (i_frame_start) begin
      // A pulse coincident with enable rising is counted (counter is 0 here).
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = 8'd0;
        blink_state_d = (blink_state_q == ST_VIS) ? ST_HID : ST_VIS;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour key and blink gating
  // ---------------------------------------------------------------------------
  logic        vis;
  logic        valid_d, valid_q;
  logic        hit_d,   hit_q;
  logic [23:0] rgb_d,   rgb_q;

  always_comb begin
    vis     = (blink_state_q == ST_VIS);
    valid_d = s1_valid_q;
    hit_d   = s1_in_q && (i_rom_data != KEY_RGB) && vis;
    rgb_d   = hit_d ? i_rom_data : 24'h0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_addr_q    <= 8'd0;
      s1_valid_q    <= 1'b0;
      s1_in_q       <= 1'b0;
      valid_q       <= 1'b0;
      hit_q         <= 1'b0;
      rgb_q         <= 24'h0;
      blink_state_q <= ST_VIS;
      blink_cnt_q   <= 8'd0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_in_q       <= s1_in_d;
      valid_q       <= valid_d;
      hit_q         <= hit_d;
      rgb_q         <= rgb_d;
      blink_state_q <= blink_state_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_valid    = valid_q;
  assign o_hit      = hit_q;
  assign o_rgb      = rgb_q;

endmodule

// File: tb/tb_snake_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_snake_sprite_renderer
//
// Directed bench. The sprite ROM is modelled as: addresses with col[1:0]==1
// return the colour key, every other address returns {16'hc3ed, addr}.
// Each probe drives one pixel, checks the ROM address one clock later and
// valid/hit/rgb two clocks later.
// -----------------------------------------------------------------------------
module tb_snake_sprite_renderer;

  localparam int          XW  = 10;
  localparam logic [23:0] KEY = 24'h181b1d;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [XW-1:0] i_px = '0;
  logic [XW-1:0] i_py = '0;
  logic [XW-1:0] i_org_x = '0;
  logic [XW-1:0] i_org_y = '0;
  logic [1:0]    i_dir = 2'd0;
  logic          i_frame_start = 1'b0;
  logic          i_blink_en = 1'b0;
  logic [7:0]    o_rom_addr;
  logic [23:0]   rom_data;
  logic          o_valid;
  logic          o_hit;
  logic [23:0]   o_rgb;

  always #5 clk = ~clk;

  snake_sprite_renderer #(
    .XW           (XW),
    .KEY_RGB      (KEY),
    .BLINK_FRAMES (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (i_valid),
    .i_px          (i_px),
    .i_py          (i_py),
    .i_org_x       (i_org_x),
    .i_org_y       (i_org_y),
    .i_dir         (i_dir),
    .i_frame_start (i_frame_start),
    .i_blink_en    (i_blink_en),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (rom_data),
    .o_valid       (o_valid),
    .o_hit         (o_hit),
    .o_rgb         (o_rgb)
  );

  // Sprite ROM model
  always_comb begin
    rom_data = (o_rom_addr[1:0] == 2'b01) ? KEY : {16'hc3ed, o_rom_addr};
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic pix(input string tag, input logic vld, input int px, input int py,
                     input logic [7:0] ea, input logic eh, input logic [23:0] ergb);
    @(negedge clk);
    i_valid = vld;
    i_px    = XW'(px);
    i_py    = XW'(py);
    @(posedge clk); #1;
    check({tag, ".addr"}, 32'(o_rom_addr), 32'(ea));
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(o_valid), 32'(vld));
    check({tag, ".hit"},   32'(o_hit),   32'(eh));
    check({tag, ".rgb"},   32'(o_rgb),   32'(ergb));
  endtask

  task automatic pulse();
    @(negedge clk);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  // Probe pixel at the sprite origin: addr 0x00, colour c3ed00
  task automatic probe(input string tag, input logic vis);
    pix(tag, 1'b1, 32, 48, 8'h00, vis, vis ? 24'hc3ed00 : 24'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    i_org_x = XW'(32);
    i_org_y = XW'(48);
    #12;
    check("rst.addr",  32'(o_rom_addr), 32'h0);
    check("rst.valid", 32'(o_valid),    32'h0);
    check("rst.hit",   32'(o_hit),      32'h0);
    check("rst.rgb",   32'(o_rgb),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep one sprite row, native orientation
    for (int px = 32; px <= 47; px++) begin
      logic [7:0] a;
      logic       h;
      a = 8'(px - 32);
      h = (a[1:0] != 2'b01);
      pix($sformatf("sweep%0d", px), 1'b1, px, 48, a, h, h ? {16'hc3ed, a} : 24'h0);
    end

    // Orientation at u=3, v=0
    i_dir = 2'd0; pix("dir0", 1'b1, 35, 48, 8'h03, 1'b1, 24'hc3ed03);
    i_dir = 2'd1; pix("dir1", 1'b1, 35, 48, 8'hc0, 1'b1, 24'hc3edc0);
    i_dir = 2'd2; pix("dir2", 1'b1, 35, 48, 8'hfc, 1'b1, 24'hc3edfc);
    i_dir = 2'd3; pix("dir3", 1'b1, 35, 48, 8'h3f, 1'b1, 24'hc3ed3f);
    i_dir = 2'd0;

    // Box boundaries
    pix("left_out",  1'b1, 31, 50, 8'h00, 1'b0, 24'h0);
    pix("right_out", 1'b1, 48, 50, 8'h00, 1'b0, 24'h0);
    pix("bot_in",    1'b1, 32, 63, 8'hf0, 1'b1, 24'hc3edf0);
    pix("bot_out",   1'b1, 32, 64, 8'h00, 1'b0, 24'h0);
    pix("no_valid",  1'b0, 35, 48, 8'h00, 1'b0, 24'h0);

    // Colour key and opaque colour
    pix("key",    1'b1, 33, 48, 8'h01, 1'b0, 24'h0);
    pix("opaque", 1'b1, 32, 56, 8'h80, 1'b1, 24'hc3ed80);

    // Origin near the right screen edge: no wrap to x=0
    i_org_x = XW'(1020);
    pix("edge_in",   1'b1, 1023, 48, 8'h03, 1'b1, 24'hc3ed03);
    pix("edge_wrap", 1'b1, 0,    48, 8'h00, 1'b0, 24'h0);
    i_org_x = XW'(32);

    // Blink with BLINK_FRAMES=2: VIS,VIS,HID,HID,VIS
    @(negedge clk);
    i_blink_en = 1'b1;
    probe("blink_f0", 1'b1);
    pulse(); probe("blink_f1", 1'b1);
    pulse(); probe("blink_f2", 1'b0);
    pulse(); probe("blink_f3", 1'b0);
    pulse(); probe("blink_f4", 1'b1);
    pulse(); pulse(); probe("blink_hid", 1'b0);
    @(negedge clk);
    i_blink_en = 1'b0;
    probe("blink_drop", 1'b1);

    // Pulse coincident with enable rising is counted
    @(negedge clk);
    i_blink_en    = 1'b1;
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    pulse();
    probe("blink_coinc", 1'b0);
    @(negedge clk);
    i_blink_en = 1'b0;
    probe("blink_off", 1'b1);

    // Asynchronous reset mid-line
    @(negedge clk);
    i_valid = 1'b1;
    i_px    = XW'(35);
    i_py    = XW'(48);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst.hit", 32'(o_hit), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.addr",  32'(o_rom_addr), 32'h0);
    check("arst.valid", 32'(o_valid),    32'h0);
    check("arst.hit",   32'(o_hit),      32'h0);
    check("arst.rgb",   32'(o_rgb),      32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel1.valid", 32'(o_valid),    32'h0);
    check("rel1.addr",  32'(o_rom_addr), 32'h03);
    @(posedge clk); #1;
    check("rel2.valid", 32'(o_valid), 32'h1);
    check("rel2.hit",   32'(o_hit),   32'h1);
    check("rel2.rgb",   32'(o_rgb),   32'hc3ed03);
    @(negedge clk);
    i_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
